// File: rtl/mfp_srec_word_packer_ahb_bridge.sv
// Packs S-record parser bytes into aligned words and drains them as single AHB-Lite writes.
// Ports: HCLK/HRESETn, byte stream (write_*, flush, big_endian), AHB-Lite master, busy/overflow.
module mfp_srec_word_packer_ahb_bridge #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        big_endian,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  input  logic        flush,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  // lowest remaining byte offset; big-endian lanes are reversed
  function automatic logic [1:0] next_off(
    input logic [3:0] m,
    input logic       be
  );
    logic [3:0] om;
    om = be ? {m[0], m[1], m[2], m[3]} : m;
    if (om[0])      next_off = 2'd0;
    else if (om[1]) next_off = 2'd1;
    else if (om[2]) next_off = 2'd2;
    else            next_off = 2'd3;
  endfunction

  logic [29:0] p_tag, n_tag, push_tag;
  logic [31:0] p_data, n_data, push_data;
  logic [3:0]  p_mask, n_mask, push_mask;
  logic        p_be, n_be, push_be;
  logic        push, pop, accept;

  logic [29:0] f_tag  [FIFO_DEPTH];
  logic [31:0] f_data [FIFO_DEPTH];
  logic [3:0]  f_mask [FIFO_DEPTH];
  logic        f_be   [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;

  state_t      state;
  logic [29:0] c_tag;
  logic [31:0] c_data;
  logic [3:0]  c_mask, rem_after;
  logic [1:0]  c_lane, h_off, r_off;
  logic        c_be, c_word;

  logic [1:0]  in_lane;
  logic [4:0]  in_sh;
  logic [31:0] fresh_d;
  logic [3:0]  fresh_m;

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;

  assign in_lane = big_endian ? ~write_address[1:0] : write_address[1:0];
  assign in_sh   = {in_lane, 3'b000};
  assign fresh_d = 32'(write_byte) << in_sh;
  assign fresh_m = 4'b0001 << in_lane;

  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    push      = 1'b0;
    push_tag  = p_tag;
    push_data = p_data;
    push_mask = p_mask;
    push_be   = p_be;
    n_tag     = p_tag;
    n_data    = p_data;
    n_mask    = p_mask;
    n_be      = p_be;
    if (p_mask == 4'hF) begin
      // full word leaves now; a byte arriving alongside starts a new entry
      push   = 1'b1;
      n_tag  = write_address[31:2];
      n_data = fresh_d;
      n_mask = write_enable ? fresh_m : 4'h0;
      n_be   = big_endian;
    end else if (write_enable && p_mask != 4'h0 &&
                 write_address[31:2] != p_tag) begin
      push   = 1'b1;
      n_tag  = write_address[31:2];
      n_data = fresh_d;
      n_mask = fresh_m;
      n_be   = big_endian;
    end else begin
      if (write_enable) begin
        n_tag  = write_address[31:2];
        n_data = (p_data & ~(32'hFF << in_sh)) | fresh_d;
        n_mask = p_mask | fresh_m;
        n_be   = big_endian;
      end
      if (flush && n_mask != 4'h0) begin
        push      = 1'b1;
        push_tag  = n_tag;
        push_data = n_data;
        push_mask = n_mask;
        push_be   = n_be;
        n_mask    = 4'h0;
      end
    end
  end

  assign rem_after = c_mask & ~(4'b0001 << c_lane);
  assign pop       = (state == S_DATA) && HREADY &&
                     (c_word || rem_after == 4'h0);
  assign accept    = push && (!fifo_full || pop);
  assign h_off     = next_off(f_mask[rd_ptr[AW-1:0]], f_be[rd_ptr[AW-1:0]]);
  assign r_off     = next_off(rem_after, c_be);
  assign busy      = (p_mask != 4'h0) || !fifo_empty || (state != S_IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p_tag    <= '0;
      p_data   <= '0;
      p_mask   <= '0;
      p_be     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      p_tag  <= n_tag;
      p_data <= n_data;
      p_mask <= n_mask;
      p_be   <= n_be;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !accept) overflow <= 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      f_tag[wr_ptr[AW-1:0]]  <= push_tag;
      f_data[wr_ptr[AW-1:0]] <= push_data;
      f_mask[wr_ptr[AW-1:0]] <= push_mask;
      f_be[wr_ptr[AW-1:0]]   <= push_be;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= S_IDLE;
      c_tag  <= '0;
      c_data <= '0;
      c_mask <= '0;
      c_lane <= '0;
      c_be   <= 1'b0;
      c_word <= 1'b0;
      HADDR  <= '0;
      HSIZE  <= 3'b010;
      HTRANS <= 2'b00;
      HWDATA <= '0;
      HWRITE <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            c_tag  <= f_tag[rd_ptr[AW-1:0]];
            c_data <= f_data[rd_ptr[AW-1:0]];
            c_mask <= f_mask[rd_ptr[AW-1:0]];
            c_be   <= f_be[rd_ptr[AW-1:0]];
            c_lane <= f_be[rd_ptr[AW-1:0]] ? ~h_off : h_off;
            HTRANS <= 2'b10;
            HWRITE <= 1'b1;
            state  <= S_ADDR;
            if (f_mask[rd_ptr[AW-1:0]] == 4'hF) begin
              c_word <= 1'b1;
              HSIZE  <= 3'b010;
              HADDR  <= {f_tag[rd_ptr[AW-1:0]], 2'b00};
            end else begin
              c_word <= 1'b0;
              HSIZE  <= 3'b000;
              HADDR  <= {f_tag[rd_ptr[AW-1:0]], h_off};
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            HTRANS <= 2'b00;
            HWRITE <= 1'b0;
            HWDATA <= c_word ? c_data :
                      {4{c_data[{c_lane, 3'b000} +: 8]}};
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (HREADY) begin
            if (pop) begin
              state <= S_IDLE;
            end else begin
              c_mask <= rem_after;
              c_lane <= c_be ? ~r_off : r_off;
              HADDR  <= {c_tag, r_off};
              HTRANS <= 2'b10;
              HWRITE <= 1'b1;
              state  <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_srec_word_packer_ahb_bridge.sv
// Randomised and directed bench for the S-record word packer AHB bridge.
// Scoreboard model predicts every bus transfer, busy and overflow.
module tb_mfp_srec_word_packer_ahb_bridge;

  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        big_endian = 1'b0;
  logic [31:0] write_address = '0;
  logic [7:0]  write_byte = '0;
  logic        write_enable = 1'b0;
  logic        flush = 1'b0;
  logic        HREADY = 1'b1;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        busy;
  logic        overflow;

  mfp_srec_word_packer_ahb_bridge #(
    .FIFO_DEPTH (DEPTH),
    .HPROT_VALUE(4'b0011)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .big_endian   (big_endian),
    .write_address(write_address),
    .write_byte   (write_byte),
    .write_enable (write_enable),
    .flush        (flush),
    .HREADY       (HREADY),
    .HADDR        (HADDR),
    .HBURST       (HBURST),
    .HMASTLOCK    (HMASTLOCK),
    .HPROT        (HPROT),
    .HSIZE        (HSIZE),
    .HTRANS       (HTRANS),
    .HWDATA       (HWDATA),
    .HWRITE       (HWRITE),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    bit          last;
  } xfer_t;

  int errors = 0;
  int checks = 0;

  xfer_t m_q[$];
  xfer_t log_q[$];
  logic [29:0] m_tag;
  logic [7:0]  mb[4];
  logic [3:0]  mv;
  logic        m_be;
  int          m_cnt;
  bit          m_ovf;

  logic [29:0] e_tag;
  logic [7:0]  eb[4];
  logic [3:0]  ev;
  logic        e_be;
  bit          m_push;

  bit          in_data, st_addr, st_data, pop;
  xfer_t       cur;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_size;

  bit hr_rand = 0;
  bit hr_val = 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic take_entry();
    e_tag  = m_tag;
    e_be   = m_be;
    ev     = mv;
    for (int i = 0; i < 4; i++) eb[i] = mb[i];
    m_push = 1;
    mv     = 4'h0;
  endtask

  task automatic add_byte();
    m_tag = write_address[31:2];
    mb[write_address[1:0]] = write_byte;
    mv[write_address[1:0]] = 1'b1;
    m_be = big_endian;
  endtask

  // an accepted entry becomes one word write or ascending byte writes
  task automatic enqueue();
    xfer_t x;
    logic [31:0] w;
    int hi;
    if (ev == 4'hF) begin
      w = '0;
      for (int off = 0; off < 4; off++)
        w[8*(e_be ? 3 - off : off) +: 8] = eb[off];
      x = '{{e_tag, 2'b00}, 3'd2, w, 1'b1};
      m_q.push_back(x);
    end else begin
      hi = 0;
      for (int off = 0; off < 4; off++) if (ev[off]) hi = off;
      for (int off = 0; off < 4; off++)
        if (ev[off]) begin
          x = '{{e_tag, 2'(off)}, 3'd0, {4{eb[off]}}, off == hi};
          m_q.push_back(x);
        end
    end
  endtask

  task automatic model_step(input bit popped);
    m_push = 0;
    if (mv == 4'hF) begin
      take_entry();
      if (write_enable) add_byte();
    end else if (write_enable && mv != 4'h0 &&
                 write_address[31:2] != m_tag) begin
      take_entry();
      add_byte();
    end else begin
      if (write_enable) add_byte();
      if (flush && mv != 4'h0) take_entry();
    end
    if (m_push) begin
      if (m_cnt < DEPTH || popped) begin
        enqueue();
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end
    if (popped) m_cnt--;
  endtask

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      m_q.delete();
      mv = 4'h0;
      m_cnt = 0;
      m_ovf = 0;
      in_data = 0;
      st_addr = 0;
      st_data = 0;
    end else begin
      chk("hburst", 32'(HBURST), 32'd0);
      chk("hmastlock", 32'(HMASTLOCK), 32'd0);
      chk("hprot", 32'(HPROT), 32'h3);
      chk("busy", 32'(busy), 32'((mv != 4'h0) || (m_cnt > 0)));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (st_addr) begin
        chk("hold_haddr", HADDR, p_addr);
        chk("hold_htrans", 32'(HTRANS), 32'd2);
        chk("hold_hsize", 32'(HSIZE), 32'(p_size));
      end
      if (st_data) chk("hold_hwdata", HWDATA, p_wdata);
      pop = 0;
      st_addr = 0;
      st_data = 0;
      if (in_data) begin
        chk("data_htrans", 32'(HTRANS), 32'd0);
        if (HREADY) begin
          chk("hwdata", HWDATA, cur.data);
          log_q.push_back('{cur.addr, cur.size, HWDATA, cur.last});
          pop = cur.last;
          in_data = 0;
        end else begin
          st_data = 1;
          p_wdata = HWDATA;
        end
      end else if (HTRANS == 2'b10) begin
        if (HREADY) begin
          if (m_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer: got addr %h expected none", HADDR);
            cur = '{HADDR, HSIZE, 32'h0, 1'b0};
          end else begin
            cur = m_q.pop_front();
            chk("haddr", HADDR, cur.addr);
            chk("hsize", 32'(HSIZE), 32'(cur.size));
            chk("hwrite", 32'(HWRITE), 32'd1);
          end
          in_data = 1;
        end else begin
          st_addr = 1;
          p_addr = HADDR;
          p_size = HSIZE;
        end
      end
      model_step(pop);
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
    HREADY = hr_rand ? ($urandom_range(0, 3) != 0) : hr_val;
    write_enable = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wb(input logic [31:0] a, input logic [7:0] d,
                    input logic be);
    step();
    write_enable = 1'b1;
    write_address = a;
    write_byte = d;
    big_endian = be;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    hr_rand = 0;
    hr_val = 1;
    step();
    flush = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy && m_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic wait_nonseq();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (HTRANS == 2'b10) begin
        seen = 1;
        break;
      end
    end
    chk("nonseq_seen", 32'(seen), 32'd1);
  endtask

  task automatic chk_log(input int idx, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] d);
    if (log_q.size() > idx) begin
      chk("log_addr", log_q[idx].addr, a);
      chk("log_size", 32'(log_q[idx].size), 32'(sz));
      chk("log_data", log_q[idx].data, d);
    end else begin
      chk("log_len", 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd2);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 32'd0);
    chk("rst_hprot", 32'(HPROT), 32'h3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 HRESETn = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) step();
    HRESETn = 1'b1;

    log_q.delete();
    wb(32'h100, 8'h11, 0);
    wb(32'h101, 8'h22, 0);
    wb(32'h102, 8'h33, 0);
    wb(32'h103, 8'h44, 0);
    drain();
    chk("t1_n", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h100, 3'd2, 32'h44332211);

    log_q.delete();
    wb(32'h100, 8'h11, 1);
    wb(32'h101, 8'h22, 1);
    wb(32'h102, 8'h33, 1);
    wb(32'h103, 8'h44, 1);
    drain();
    chk_log(0, 32'h100, 3'd2, 32'h11223344);

    log_q.delete();
    wb(32'h201, 8'hAA, 0);
    wb(32'h203, 8'hBB, 0);
    drain();
    chk("t3_n", 32'(log_q.size()), 32'd2);
    chk_log(0, 32'h201, 3'd0, 32'hAAAAAAAA);
    chk_log(1, 32'h203, 3'd0, 32'hBBBBBBBB);

    log_q.delete();
    wb(32'h300, 8'hCC, 0);
    wb(32'h404, 8'hDD, 0);
    repeat (10) step();
    chk("t4_pending_n", 32'(log_q.size()), 32'd1);
    chk("t4_pending_busy", 32'(busy), 32'd1);
    chk_log(0, 32'h300, 3'd0, 32'hCCCCCCCC);
    drain();
    chk_log(1, 32'h404, 3'd0, 32'hDDDDDDDD);

    log_q.delete();
    hr_val = 0;
    wb(32'h500, 8'h01, 0);
    wb(32'h501, 8'h02, 0);
    wb(32'h502, 8'h03, 0);
    wb(32'h503, 8'h04, 0);
    wait_nonseq();
    repeat (5) step();
    hr_val = 1;
    step();
    hr_val = 0;
    repeat (5) step();
    drain();
    chk("t5_n", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h500, 3'd2, 32'h04030201);

    for (int ph = 0; ph < 2; ph++) begin
      hr_rand = 1;
      big_endian = ph[0];
      for (int i = 0; i < 400; i++) begin
        step();
        if ($urandom_range(0, 1) == 1) begin
          write_enable = 1'b1;
          write_address = 32'h2000 + ($urandom_range(0, 5) << 2) +
                          $urandom_range(0, 3);
          write_byte = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 15) == 0) flush = 1'b1;
      end
      drain();
    end

    log_q.delete();
    hr_val = 0;
    for (int k = 0; k <= DEPTH; k++)
      for (int j = 0; j < 4; j++)
        wb(32'h600 + 32'(4 * k + j), 8'(16 * k + j), 0);
    repeat (3) step();
    chk("t6_overflow", 32'(overflow), 32'd1);
    drain();
    chk("t6_n", 32'(log_q.size()), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++)
      chk_log(k, 32'h600 + 32'(4 * k), 3'd2,
              {8'(16 * k + 3), 8'(16 * k + 2), 8'(16 * k + 1), 8'(16 * k)});

    hr_val = 0;
    wb(32'h700, 8'h9A, 0);
    wb(32'h701, 8'h9B, 0);
    wb(32'h702, 8'h9C, 0);
    wb(32'h703, 8'h9D, 0);
    wait_nonseq();
    hr_val = 1;
    step();
    hr_val = 0;
    step();
    chk("t7_in_data", 32'(HTRANS), 32'd0);
    chk("t7_hwdata", HWDATA, 32'h9D9C9B9A);
    #2 HRESETn = 1'b0;
    #1 chk_reset_outputs();
    repeat (2) step();
    HRESETn = 1'b1;
    hr_val = 1;

    log_q.delete();
    wb(32'h800, 8'h55, 0);
    wb(32'h801, 8'h66, 0);
    wb(32'h802, 8'h77, 0);
    wb(32'h803, 8'h88, 0);
    drain();
    chk("t8_n", 32'(log_q.size()), 32'd1);
    chk_log(0, 32'h800, 3'd2, 32'h88776655);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mfp_srec_word_packer_ahb_bridge.md
Name: mfp_srec_word_packer_ahb_bridge

Overview:
Loader-side AHB-Lite master that sits between the S-record parser byte stream and the AHB-Lite matrix input multiplexer. It packs consecutive bytes that fall in the same aligned word into one 32-bit write, and buffers the packed words in a small FIFO. It then issues single, non-pipelined AHB-Lite write transfers under HREADY flow control. Full words become word writes; partial words become per-byte writes.

Parameters:
FIFO_DEPTH, 4, number of packed-word entries buffered (power of 2, at least 2)
HPROT_VALUE, 4'b0011, constant driven on HPROT (non-cacheable data access)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
big_endian  in  1  byte-lane ordering, sampled per byte
write_address  in  32  byte address from parser
write_byte  in  8  byte data from parser
write_enable  in  1  one-cycle strobe, byte valid
flush  in  1  one-cycle strobe, push partially packed word
HREADY  in  1  matrix ready
HADDR  out  32  transfer address
HBURST  out  3  always 3'b000 (SINGLE)
HMASTLOCK  out  1  always 0
HPROT  out  4  HPROT_VALUE
HSIZE  out  3  3'b010 word / 3'b000 byte
HTRANS  out  2  2'b00 IDLE / 2'b10 NONSEQ
HWDATA  out  32  write data, data phase
HWRITE  out  1  1 during address phase
busy  out  1  packer, FIFO or FSM non-idle
overflow  out  1  sticky: entry dropped because FIFO full

Behaviour:
- Reset (asynchronous, HRESETn low):
  - Packer, FIFO and FSM cleared; any in-flight transfer is abandoned.
  - HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=010, HBURST=000, HMASTLOCK=0, HPROT=HPROT_VALUE, busy=0, overflow=0.
- Packer holds: word tag addr[31:2], a 32-bit data register and a 4-bit valid mask.
- Byte lane for each byte: lane = addr[1:0] when big_endian=0, 3-addr[1:0] when big_endian=1. The byte is written to bits 8*lane+7:8*lane and mask[lane] is set.
- write_enable with the packer empty or the tag matching: merge the byte. A repeated byte address overwrites the earlier value.
- write_enable with a tag mismatch while the packer is non-empty: in the same cycle, push the old entry and load the new byte as a fresh entry.
- When the mask becomes 4'b1111: push the entry next cycle and empty the packer.
- flush: push a non-empty packer. If write_enable is in the same cycle, the byte is merged first and the combined entry is pushed. flush with an empty packer does nothing.
- Push with FIFO full: the entry is dropped and overflow is set. Overflow is cleared only by reset.
- Push and pop in the same cycle with the FIFO full: allowed, no overflow.
- Master FSM states: IDLE, ADDR, DATA.
  - IDLE: when the FIFO is non-empty, read the head entry and go to ADDR.
  - ADDR: HTRANS=NONSEQ, HWRITE=1.
    - Mask 1111: HSIZE=010, HADDR={tag,2'b00}.
    - Otherwise: HSIZE=000, HADDR={tag, byte offset of the lowest remaining set lane, mapped back through the endian rule}.
    - Hold the address phase until HREADY=1, then go to DATA.
  - DATA: HTRANS=IDLE. HWDATA=packed word for a word write, or the byte replicated on all four lanes for a byte write. Hold until HREADY=1.
    - If byte lanes remain: clear the done lane and go to ADDR.
    - Otherwise: pop the FIFO and go to IDLE.
- Byte order within a partial word: ascending byte address.
- Minimum latency from a full-word push to NONSEQ on the bus: 1 cycle. Each transfer takes at least 2 cycles.
- busy = packer non-empty OR FIFO non-empty OR FSM != IDLE. The top level holds in_progress while busy, so the CPU resumes only after the last write completes.
- Address outputs change only in IDLE->ADDR or DATA->ADDR transitions. They stay stable while HREADY=0 during the address phase.

Test Plan:
- LE, bytes 11,22,33,44 to 0x100..0x103 -> one transfer: HADDR=0x100, HSIZE=010, HWDATA=0x44332211.
- BE, same bytes -> HWDATA=0x11223344.
- LE, bytes AA to 0x201 and BB to 0x203, then flush -> two byte writes at 0x201 then 0x203; HWDATA=0xAAAAAAAA then 0xBBBBBBBB.
- Byte to 0x300, then byte to 0x404 -> 0x300 byte write pushed on the tag change; the 0x404 byte stays pending until flush.
- Hold HREADY=0 for 5 cycles in the address and data phases -> HADDR/HTRANS/HWDATA stable; exactly one transfer per entry.
- With HREADY=0 held, push FIFO_DEPTH+1 words -> overflow=1, and the first FIFO_DEPTH words are written after HREADY is released.
- Assert HRESETn low mid-DATA phase -> all outputs return to their reset values immediately; busy=0.
